dac_control: RTL and testbench

Serial DAC write controller for the monitor/drive board: accepts 24-bit DAC command words from the register/I2C side and shifts them MSB-first to an external SPI DAC using CSn, SCK, SDI, and an optional LDACn load pulse. It is the transmit counterpart to the ADC monitor path and sets analog levels such as the DDS/CW drive and current-limit references. A one-entry pending buffer absorbs a back-to-back write request, and dropped requests are flagged in a sticky status bit.

---
 rtl/dac_if.sv | 32 +++
 rtl/dac_control.sv | 188 ++++++++++++++++++
 tb/tb_dac_control.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_if
// Purpose  : Write-request and SPI pin bundle for the serial DAC controller.
// Revision : 1.0  initial release
// ============================================================================
interface dac_if ();
   logic        dac_write;
   logic [3:0]  dac_cmd;
   logic [3:0]  dac_addr;
   logic [15:0] dac_data;
   logic        dac_ldac_en;
   logic        dac_status_clear;
   logic        dac_busy;
   logic        dac_done;
   logic        dac_overflow;
   logic        dac_csn;
   logic        dac_sck;
   logic        dac_sdi;
   logic        dac_ldacn;

   modport master (
      output dac_write, dac_cmd, dac_addr, dac_data, dac_ldac_en, dac_status_clear,
      input  dac_busy, dac_done, dac_overflow, dac_csn, dac_sck, dac_sdi, dac_ldacn
   );

   modport slave (
      input  dac_write, dac_cmd, dac_addr, dac_data, dac_ldac_en, dac_status_clear,
      output dac_busy, dac_done, dac_overflow, dac_csn, dac_sck, dac_sdi, dac_ldacn
   );
endinterface
`default_nettype wire

// File: rtl/dac_control.sv
`default_nettype none
// ============================================================================
// Module   : dac_control
// Purpose  : Shifts 24-bit DAC command words MSB-first to an SPI DAC, with an
//            optional LDACn pulse and a one-entry pending request buffer.
// Revision : 1.0  initial release
// ============================================================================
module dac_control #(
   parameter int SCK_DIV    = 2,
   parameter int CS_SETUP   = 2,
   parameter int LDAC_WIDTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   dac_if.slave  bus
);
   localparam int c_max_wait = (SCK_DIV > CS_SETUP)
                             ? ((SCK_DIV  > LDAC_WIDTH) ? SCK_DIV  : LDAC_WIDTH)
                             : ((CS_SETUP > LDAC_WIDTH) ? CS_SETUP : LDAC_WIDTH);
   localparam int c_cnt_w = $clog2(c_max_wait + 1);
   localparam logic [c_cnt_w-1:0] c_sck_load   = c_cnt_w'(SCK_DIV - 1);
   localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'(CS_SETUP - 1);
   localparam logic [c_cnt_w-1:0] c_ldac_load  = c_cnt_w'(LDAC_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_LDAC  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [22:0]          r_shift;
   logic [4:0]           r_bit;
   logic                 r_ldac_en;
   logic                 r_pend_valid;
   logic [23:0]          r_pend_frame;
   logic                 r_pend_ldac;
   logic                 r_csn;
   logic                 r_sck;
   logic                 r_sdi;
   logic                 r_ldacn;
   logic                 r_done;
   logic                 r_overflow;

   logic [23:0] w_frame_in;
   logic        w_idle;
   logic        w_store;
   logic        w_drop;
   logic        w_cnt_zero;

   assign w_frame_in = {bus.dac_cmd, bus.dac_addr, bus.dac_data};
   assign w_idle     = (r_state == ST_IDLE);
   assign w_store    = bus.dac_write & ~r_pend_valid & ~w_idle;
   assign w_drop     = bus.dac_write &  r_pend_valid & ~w_idle;
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_bit        <= '0;
         r_ldac_en    <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_frame <= '0;
         r_pend_ldac  <= 1'b0;
         r_csn        <= 1'b1;
         r_sck        <= 1'b0;
         r_sdi        <= 1'b0;
         r_ldacn      <= 1'b1;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // A drop in the same cycle as a clear leaves the flag set
         if (w_drop)
            r_overflow <= 1'b1;
         else if (bus.dac_status_clear)
            r_overflow <= 1'b0;

         if (w_store) begin
            r_pend_valid <= 1'b1;
            r_pend_frame <= w_frame_in;
            r_pend_ldac  <= bus.dac_ldac_en;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_pend_valid || bus.dac_write) begin
                  // Pending entry goes first; a simultaneous request refills it
                  if (r_pend_valid) begin
                     r_shift      <= r_pend_frame[22:0];
                     r_sdi        <= r_pend_frame[23];
                     r_ldac_en    <= r_pend_ldac;
                     r_pend_valid <= bus.dac_write;
                     if (bus.dac_write) begin
                        r_pend_frame <= w_frame_in;
                        r_pend_ldac  <= bus.dac_ldac_en;
                     end
                  end else begin
                     r_shift   <= w_frame_in[22:0];
                     r_sdi     <= w_frame_in[23];
                     r_ldac_en <= bus.dac_ldac_en;
                  end
                  r_csn   <= 1'b0;
                  r_bit   <= 5'd23;
                  r_cnt   <= c_setup_load;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_cnt_zero) begin
                  r_sck   <= 1'b1;
                  r_cnt   <= c_sck_load;
                  r_state <= ST_HIGH;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HIGH: begin
               if (w_cnt_zero) begin
                  r_sck <= 1'b0;
                  r_cnt <= c_sck_load;
                  if (r_bit == 5'd0) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_bit   <= r_bit - 1'b1;
                     r_sdi   <= r_shift[22];
                     r_shift <= {r_shift[21:0], 1'b0};
                     r_state <= ST_LOW;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_LOW: begin
               if (w_cnt_zero) begin
                  r_sck   <= 1'b1;
                  r_cnt   <= c_sck_load;
                  r_state <= ST_HIGH;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_cnt_zero) begin
                  r_csn <= 1'b1;
                  if (r_ldac_en) begin
                     r_ldacn <= 1'b0;
                     r_cnt   <= c_ldac_load;
                     r_state <= ST_LDAC;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_LDAC: begin
               if (w_cnt_zero) begin
                  r_ldacn <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.dac_busy     = ~w_idle | r_pend_valid;
   assign bus.dac_done     = r_done;
   assign bus.dac_overflow = r_overflow;
   assign bus.dac_csn      = r_csn;
   assign bus.dac_sck      = r_sck;
   assign bus.dac_sdi      = r_sdi;
   assign bus.dac_ldacn    = r_ldacn;
endmodule
`default_nettype wire

// File: tb/tb_dac_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_control
// Purpose  : Self-checking bench for dac_control (default and fastest timing).
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_control;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dac_if bus0 ();
   dac_if bus1 ();

   dac_control #(.SCK_DIV(2), .CS_SETUP(2), .LDAC_WIDTH(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   dac_control #(.SCK_DIV(1), .CS_SETUP(1), .LDAC_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_on = 1'b0;

   // Outputs packed as {csn, sck, sdi, ldacn, busy, done, overflow}
   logic [6:0] outs [2];
   assign outs[0] = {bus0.dac_csn, bus0.dac_sck, bus0.dac_sdi, bus0.dac_ldacn,
                     bus0.dac_busy, bus0.dac_done, bus0.dac_overflow};
   assign outs[1] = {bus1.dac_csn, bus1.dac_sck, bus1.dac_sdi, bus1.dac_ldacn,
                     bus1.dac_busy, bus1.dac_done, bus1.dac_overflow};

   function automatic int p_cs(int k); return (k == 0) ? 2 : 1; endfunction
   function automatic int p_dv(int k); return (k == 0) ? 2 : 1; endfunction
   function automatic int p_lw(int k); return (k == 0) ? 4 : 1; endfunction

   // Model: list of accepted frames with write cycle, CSn-fall cycle, done cycle
   int          nf [2];
   int          fa [2][32];
   int          fs [2][32];
   int          fe [2][32];
   logic [23:0] fw [2][32];
   bit          fl [2][32];
   bit          m_ovf [2];

   function automatic void model_step(int k, bit r, bit wr, logic [23:0] w, bit le, bit clr, int c);
      bit drop;
      bit pend;
      int s;
      int li;
      drop = 1'b0;
      if (r) begin
         nf[k] = 0;
         m_ovf[k] = 1'b0;
         return;
      end
      if (wr) begin
         li = nf[k] - 1;
         if (nf[k] == 0 || c > fe[k][li]) begin
            s = c + 1;
         end else begin
            pend = (c >= fa[k][li] + 1) && (c <= fs[k][li] - 1);
            if (pend && c != fs[k][li] - 1) drop = 1'b1;
            s = fe[k][li] + 2;
         end
         if (!drop && nf[k] < 32) begin
            fa[k][nf[k]] = c;
            fs[k][nf[k]] = s;
            fe[k][nf[k]] = s + p_cs(k) + 48 * p_dv(k) + (le ? p_lw(k) : 0);
            fw[k][nf[k]] = w;
            fl[k][nf[k]] = le;
            nf[k]++;
         end
      end
      if (drop) m_ovf[k] = 1'b1;
      else if (clr) m_ovf[k] = 1'b0;
   endfunction

   function automatic logic [6:0] model_exp(int k, int c);
      logic e_csn, e_sck, e_sdi, e_ldacn, e_busy, e_done;
      int s, t, d, n, cs, dv, lw;
      e_csn = 1; e_sck = 0; e_sdi = 0; e_ldacn = 1; e_busy = 0; e_done = 0;
      cs = p_cs(k); dv = p_dv(k); lw = p_lw(k);
      for (int i = 0; i < nf[k]; i++) begin
         s = fs[k][i];
         t = s + cs + 48 * dv;
         if (c >= fa[k][i] + 1 && c <= fe[k][i]) e_busy = 1;
         if (c >= s) begin
            if (c < t) e_csn = 0;
            d = c - s - cs;
            if (d >= 0 && d < 48 * dv && ((d / dv) % 2 == 0)) e_sck = 1;
            n = (d < 0) ? 0 : (d + dv) / (2 * dv);
            if (n > 23) n = 23;
            e_sdi = fw[k][i][23 - n];
            if (fl[k][i] && c >= t && c < t + lw) e_ldacn = 0;
            if (c == fe[k][i]) e_done = 1;
         end
      end
      return {e_csn, e_sck, e_sdi, e_ldacn, e_busy, e_done, m_ovf[k]};
   endfunction

   always @(posedge clk) begin
      model_step(0, rst, bus0.dac_write, {bus0.dac_cmd, bus0.dac_addr, bus0.dac_data},
                 bus0.dac_ldac_en, bus0.dac_status_clear, cyc);
      model_step(1, rst, bus1.dac_write, {bus1.dac_cmd, bus1.dac_addr, bus1.dac_data},
                 bus1.dac_ldac_en, bus1.dac_status_clear, cyc);
      cyc = cyc + 1;
   end

   logic [6:0] cmp_exp;
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            cmp_exp = model_exp(k, cyc);
            n_chk++;
            if (outs[k] !== cmp_exp) begin
               n_err++;
               $display("FAIL cycle_compare dut%0d cyc=%0d got=%b expected=%b (csn,sck,sdi,ldacn,busy,done,ovf)",
                        k, cyc, outs[k], cmp_exp);
            end
         end
      end
   end

   // Observer acting as the SPI DAC: samples SDI on each SCK rise
   int          mon_fall [2], mon_rise [2], mon_done_cyc [2], mon_done_cnt [2];
   int          mon_ldac_cnt [2], mon_ldac_first [2], mon_rxn [2], mon_bits [2];
   logic [23:0] mon_rx [2], mon_word [2];
   logic        prev_csn [2], prev_sck [2], prev_ldacn [2];
   logic [6:0]  mo;
   initial begin
      for (int k = 0; k < 2; k++) begin
         prev_csn[k] = 1; prev_sck[k] = 0; prev_ldacn[k] = 1;
         mon_done_cnt[k] = 0; mon_ldac_cnt[k] = 0; mon_rxn[k] = 0; mon_bits[k] = 0;
         mon_fall[k] = 0; mon_rise[k] = 0; mon_done_cyc[k] = 0; mon_ldac_first[k] = 0;
         mon_rx[k] = 0; mon_word[k] = 0;
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            mo = outs[k];
            if (prev_csn[k] && !mo[6]) begin
               mon_fall[k] = cyc; mon_rx[k] = 0; mon_rxn[k] = 0;
            end
            if (!mo[6] && !prev_sck[k] && mo[5]) begin
               mon_rx[k] = {mon_rx[k][22:0], mo[4]}; mon_rxn[k]++;
            end
            if (!prev_csn[k] && mo[6]) begin
               mon_rise[k] = cyc; mon_word[k] = mon_rx[k]; mon_bits[k] = mon_rxn[k];
            end
            if (mo[1]) begin mon_done_cyc[k] = cyc; mon_done_cnt[k]++; end
            if (!mo[3]) begin
               if (prev_ldacn[k]) mon_ldac_first[k] = cyc;
               mon_ldac_cnt[k]++;
            end
            prev_csn[k] = mo[6]; prev_sck[k] = mo[5]; prev_ldacn[k] = mo[3];
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   task automatic drive(int k, bit wr, logic [3:0] cmd, logic [3:0] addr, logic [15:0] data, bit le, bit clr);
      if (k == 0) begin
         bus0.dac_write = wr; bus0.dac_cmd = cmd; bus0.dac_addr = addr;
         bus0.dac_data = data; bus0.dac_ldac_en = le; bus0.dac_status_clear = clr;
      end else begin
         bus1.dac_write = wr; bus1.dac_cmd = cmd; bus1.dac_addr = addr;
         bus1.dac_data = data; bus1.dac_ldac_en = le; bus1.dac_status_clear = clr;
      end
   endtask

   task automatic pulse(int k, bit wr, logic [3:0] cmd, logic [3:0] addr, logic [15:0] data, bit le, bit clr);
      drive(k, wr, cmd, addr, data, le, clr);
      tick();
      drive(k, 0, 4'h0, 4'h0, 16'h0, 0, 0);
   endtask

   task automatic wait_done(int k, int target, int budget);
      int n;
      n = 0;
      while (mon_done_cnt[k] < target && n < budget) begin tick(); n++; end
      check("done_within_budget", 32'(mon_done_cnt[k] >= target), 32'd1);
   endtask

   int t0;
   int dc;
   initial begin
      drive(0, 0, 4'h0, 4'h0, 16'h0, 0, 0);
      drive(1, 0, 4'h0, 4'h0, 16'h0, 0, 0);
      tick();
      chk_on = 1'b1;
      tick();
      check("reset_outputs", 32'(outs[0]), 32'b1001000);
      rst = 1'b0;
      tick(); tick();

      // Single frame, defaults
      t0 = cyc;
      pulse(0, 1, 4'h3, 4'h0, 16'hA55A, 0, 0);
      wait_done(0, 1, 300);
      check("single_word", 32'(mon_word[0]), 32'h30A55A);
      check("single_bits", 32'(mon_bits[0]), 32'd24);
      check("single_csn_fall", 32'(mon_fall[0] - t0), 32'd1);
      check("single_csn_rise", 32'(mon_rise[0] - t0), 32'd99);
      check("single_done", 32'(mon_done_cyc[0] - t0), 32'd99);
      check("single_ldacn_idle", 32'(mon_ldac_cnt[0]), 32'd0);
      repeat (5) tick();

      // LDAC frame
      t0 = cyc;
      pulse(0, 1, 4'h3, 4'h1, 16'hFFFF, 1, 0);
      wait_done(0, 2, 300);
      check("ldac_done", 32'(mon_done_cyc[0] - t0), 32'd103);
      check("ldac_first_low", 32'(mon_ldac_first[0] - t0), 32'd99);
      check("ldac_width", 32'(mon_ldac_cnt[0]), 32'd4);
      wait_until(t0 + 104);
      check("ldac_busy_low", 32'(bus0.dac_busy), 32'd0);
      repeat (5) tick();

      // Back-to-back: second request is buffered
      t0 = cyc;
      pulse(0, 1, 4'h2, 4'h5, 16'h1234, 0, 0);
      wait_until(t0 + 10);
      pulse(0, 1, 4'h2, 4'h6, 16'h0001, 0, 0);
      wait_done(0, 4, 500);
      check("b2b_second_fall", 32'(mon_fall[0] - t0), 32'd101);
      check("b2b_second_done", 32'(mon_done_cyc[0] - t0), 32'd199);
      check("b2b_second_word", 32'(mon_word[0]), 32'h260001);
      check("b2b_overflow", 32'(bus0.dac_overflow), 32'd0);
      repeat (5) tick();

      // Overflow: third request dropped, clear loses against a simultaneous drop
      t0 = cyc;
      pulse(0, 1, 4'h1, 4'h1, 16'h1111, 0, 0);
      wait_until(t0 + 5);
      pulse(0, 1, 4'h1, 4'h2, 16'h2222, 0, 0);
      check("ovf_before_drop", 32'(bus0.dac_overflow), 32'd0);
      pulse(0, 1, 4'h1, 4'h3, 16'h3333, 0, 0);
      check("ovf_set", 32'(bus0.dac_overflow), 32'd1);
      wait_until(t0 + 20);
      pulse(0, 1, 4'h1, 4'h4, 16'h4444, 0, 1);
      check("ovf_set_beats_clear", 32'(bus0.dac_overflow), 32'd1);
      wait_until(t0 + 30);
      pulse(0, 0, 4'h0, 4'h0, 16'h0, 0, 1);
      check("ovf_cleared", 32'(bus0.dac_overflow), 32'd0);
      wait_done(0, 6, 500);
      check("ovf_kept_word", 32'(mon_word[0]), 32'h122222);
      repeat (5) tick();

      // Reset mid-frame discards the frame and the pending request
      t0 = cyc;
      pulse(0, 1, 4'h7, 4'h7, 16'h7777, 1, 0);
      wait_until(t0 + 20);
      pulse(0, 1, 4'h8, 4'h8, 16'h8888, 0, 0);
      wait_until(t0 + 50);
      dc = mon_done_cnt[0];
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_outputs", {28'd0, bus0.dac_csn, bus0.dac_sck, bus0.dac_ldacn, bus0.dac_busy}, 32'b1010);
      repeat (250) tick();
      check("rst_no_done", 32'(mon_done_cnt[0]), 32'(dc));
      t0 = cyc;
      pulse(0, 1, 4'h9, 4'hC, 16'hBEEF, 0, 0);
      wait_done(0, dc + 1, 300);
      check("rst_next_word", 32'(mon_word[0]), 32'h9CBEEF);
      check("rst_next_done", 32'(mon_done_cyc[0] - t0), 32'd99);

      // Fastest timing instance
      t0 = cyc;
      pulse(1, 1, 4'hF, 4'hF, 16'hFFFF, 0, 0);
      wait_done(1, 1, 200);
      check("fast_csn_rise", 32'(mon_rise[1] - t0), 32'd50);
      check("fast_done", 32'(mon_done_cyc[1] - t0), 32'd50);
      check("fast_ones", 32'(mon_word[1]), 32'hFFFFFF);
      repeat (3) tick();
      pulse(1, 1, 4'h0, 4'h0, 16'h0000, 0, 0);
      wait_done(1, 2, 200);
      check("fast_zeros", 32'(mon_word[1]), 32'h000000);
      check("fast_zero_bits", 32'(mon_bits[1]), 32'd24);
      repeat (3) tick();
      t0 = cyc;
      pulse(1, 1, 4'hA, 4'h5, 16'h8001, 1, 0);
      wait_done(1, 3, 200);
      check("fast_ldac_done", 32'(mon_done_cyc[1] - t0), 32'd51);
      check("fast_ldac_width", 32'(mon_ldac_cnt[1]), 32'd1);
      check("fast_alt_word", 32'(mon_word[1]), 32'hA58001);
      repeat (5) tick();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
